// File: rtl/conv_weight_streamer_3x3.sv
// conv_weight_streamer_3x3
// Purpose : reads one layer of 3x3 conv weights from a synchronous weight memory and streams
//           them filter by filter into the conv weight buffer (valid_weight_in / weight_in).
// Latency : mem_rd_en -> valid_weight_out is 2 cycles; first word 3 cycles after the start pulse.
// Backpr. : hold gates new reads only, so at most 2 in-flight words still drain. Each filter after
//           the first waits for a filter_req pulse. An early pulse is kept in a 1-deep pending flag.
//
// Ports:
//   clk              clock
//   reset            asynchronous active-low reset; aborts any pass in progress
//   start            1-cycle pulse; begins a full pass at address 0 (ignored while busy)
//   hold             high = issue no new memory reads (only honoured while streaming a filter)
//   filter_req       1-cycle pulse from conv: weight buffer free for the next filter
//   mem_rd_en        memory read enable
//   mem_addr         memory read address, (co*CHANNEL_NUM_IN + ci)*K*K + r*K + c
//   mem_data         read data, valid the cycle after mem_rd_en
//   weight_out       weight word towards conv weight_in
//   valid_weight_out weight_out valid towards conv valid_weight_in
//   busy             high from start acceptance until done
//   done             1-cycle pulse, one cycle after the last word of the pass

module conv_weight_streamer_3x3 #(
  parameter int DATA_WIDTH      = 32,
  parameter int KERNEL          = 3,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 512,
  parameter int ADDR_WIDTH      = $clog2(CHANNEL_NUM_OUT*CHANNEL_NUM_IN*KERNEL*KERNEL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  filter_req,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic                  busy,
  output logic                  done
);

  // Words in one filter and counter widths (kept at least 1 bit wide).
  localparam int WPF = CHANNEL_NUM_IN * KERNEL * KERNEL;
  localparam int WCW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int COW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [WCW-1:0] LAST_WORD   = WCW'(WPF - 1);
  localparam logic [COW-1:0] LAST_FILTER = COW'(CHANNEL_NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Read-side counters.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WCW-1:0]        r_word_cnt;
  logic [COW-1:0]        r_co;

  // Early filter request remembered while the current filter is still streaming.
  logic r_pend;

  // Output pipeline: r_rd_dly marks that mem_data carries a word this cycle.
  logic                  r_rd_dly;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_weight;
  logic                  r_busy;
  logic                  r_done;

  // FSM decode strobes.
  logic w_rd_en;
  logic w_start_acc;
  logic w_last_rd;
  logic w_wait_exit;
  logic w_drain_exit;
  logic w_req_capture;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_rd) begin
          w_next_state = (r_co == LAST_FILTER) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_wait_exit) begin
          w_next_state = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_drain_exit) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_en      = 1'b0;
    w_start_acc  = 1'b0;
    w_last_rd    = 1'b0;
    w_wait_exit  = 1'b0;
    w_drain_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_acc = start;
      end
      S_RUN: begin
        w_rd_en   = !hold;
        w_last_rd = !hold && (r_word_cnt == LAST_WORD);
      end
      S_WAIT: begin
        w_wait_exit = filter_req || r_pend;
      end
      S_DRAIN: begin
        // The last read was issued on the cycle before DRAIN, so once the delayed read
        // strobe is low the final word is sitting in the output register this cycle.
        w_drain_exit = !r_rd_dly;
      end
      default: ;
    endcase
  end

  // Requests only count while a filter is streaming or draining; IDLE pulses are ignored
  // and WAIT consumes a live pulse directly.
  assign w_req_capture = filter_req && ((r_state == S_RUN) || (r_state == S_DRAIN));

  // ---------------------------------------------------------------------------
  // Address, word-in-filter and filter counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_word_cnt <= '0;
      r_co       <= '0;
    end else if (w_start_acc) begin
      r_addr     <= '0;
      r_word_cnt <= '0;
      r_co       <= '0;
    end else if (w_rd_en) begin
      r_addr <= r_addr + ADDR_WIDTH'(1);
      if (w_last_rd) begin
        r_word_cnt <= '0;
        if (r_co != LAST_FILTER) begin
          r_co <= r_co + COW'(1);
        end
      end else begin
        r_word_cnt <= r_word_cnt + WCW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending filter request (1 deep; extra pulses while set are dropped)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= 1'b0;
    end else if (w_start_acc || w_wait_exit) begin
      r_pend <= 1'b0;
    end else if (w_req_capture) begin
      r_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pipeline and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_dly <= 1'b0;
      r_valid  <= 1'b0;
      r_weight <= '0;
    end else begin
      r_rd_dly <= w_rd_en;
      r_valid  <= r_rd_dly;
      if (r_rd_dly) begin
        r_weight <= mem_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_drain_exit;
      if (w_start_acc) begin
        r_busy <= 1'b1;
      end else if (w_drain_exit) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign mem_rd_en        = w_rd_en;
  assign mem_addr         = r_addr;
  assign weight_out       = r_weight;
  assign valid_weight_out = r_valid;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_conv_weight_streamer_3x3.sv
// Directed bench for conv_weight_streamer_3x3 with KERNEL=3, CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2
// (18 words per filter, 36 per pass). The memory model returns data = address.
module tb_conv_weight_streamer_3x3;

  localparam int DW   = 32;
  localparam int K    = 3;
  localparam int CIN  = 2;
  localparam int COUT = 2;
  localparam int AW   = $clog2(COUT*CIN*K*K);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          hold;
  logic          filter_req;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] weight_out;
  logic          valid_weight_out;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  conv_weight_streamer_3x3 #(
    .DATA_WIDTH(DW), .KERNEL(K), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .hold(hold), .filter_req(filter_req),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .weight_out(weight_out), .valid_weight_out(valid_weight_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: 1-cycle read latency, contents = address.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= 32'(mem_addr);
  end

  // Monitor, sampled 1 time unit after each rising edge.
  int          cyc      = 0;
  logic [31:0] q_words[$];
  int          q_cyc[$];
  int          n_done   = 0;
  int          done_cyc = 0;
  int          n_viol   = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (valid_weight_out === 1'b1) begin
      q_words.push_back(weight_out);
      q_cyc.push_back(cyc);
      if (busy !== 1'b1) n_viol = n_viol + 1;
    end
    if (done === 1'b1) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (q_words.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(q_words.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (n_done < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(n_done >= target), 32'd1);
  endtask

  task automatic pulse_req();
    filter_req = 1'b1;
    @(negedge clk);
    filter_req = 1'b0;
  endtask

  initial begin
    int b, b2, d0, c0, w17, a, k, bad;

    rst_n = 1'b0; start = 1'b0; hold = 1'b0; filter_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wout",  weight_out,     32'd0);
    check("rst_valid", 32'(valid_weight_out), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- Basic pass, hold = 0 ----------------
    b = q_words.size(); d0 = n_done;
    start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_words(b + 18, "t1_wait_f0");
    for (int i = 0; i < 18; i++) begin
      check("t1_word_f0", q_words[b+i], 32'(i));
      check("t1_cyc_f0",  32'(q_cyc[b+i] - c0), 32'(3 + i));
    end
    w17 = q_cyc[b+17];
    repeat (4) @(negedge clk);
    check("t1_no_word_before_req", 32'(q_words.size()), 32'(b + 18));
    check("t1_busy_in_wait", 32'(busy), 32'd1);
    pulse_req();
    wait_words(b + 36, "t1_wait_f1");
    check("t1_req_to_word18", 32'(q_cyc[b+18] - w17), 32'd7);
    for (int i = 18; i < 36; i++) begin
      check("t1_word_f1", q_words[b+i], 32'(i));
      check("t1_cyc_f1",  32'(q_cyc[b+i] - q_cyc[b+18]), 32'(i - 18));
    end
    wait_done(d0 + 1, "t1_wait_done");
    check("t1_done_after_last", 32'(done_cyc - q_cyc[b+35]), 32'd1);
    check("t1_done_high",  32'(done), 32'd1);
    check("t1_busy_low_at_done", 32'(busy), 32'd0);
    check("t1_valid_low_at_done", 32'(valid_weight_out), 32'd0);
    @(negedge clk);
    check("t1_done_single", 32'(done), 32'd0);
    check("t1_done_count", 32'(n_done - d0), 32'd1);

    // ---------------- Hold stall ----------------
    b = q_words.size(); d0 = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_rd_en === 1'b1 && mem_addr == AW'(6)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t2_saw_addr6", 32'(k < 100), 32'd1);
    a = cyc;
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    check("t2_rd_en_in_hold", 32'(mem_rd_en), 32'd0);
    check("t2_addr_in_hold",  32'(mem_addr),  32'd7);
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_words(b + 18, "t2_wait_f0");
    bad = 0;
    for (int i = 0; i < 18; i++) if (q_words[b+i] !== 32'(i)) bad++;
    check("t2_seq_no_gap_no_dup", 32'(bad), 32'd0);
    check("t2_word6_time", 32'(q_cyc[b+6] - a), 32'd2);
    check("t2_word7_time", 32'(q_cyc[b+7] - a), 32'd7);
    pulse_req();
    wait_done(d0 + 1, "t2_wait_done");
    check("t2_total_words", 32'(q_words.size() - b), 32'd36);
    check("t2_last_word", q_words[b+35], 32'd35);

    // ---------------- Early request, second pulse dropped, start ignored ----------------
    repeat (3) @(negedge clk);
    b = q_words.size(); d0 = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_words(b + 11, "t3_wait_w10");
    pulse_req();
    @(negedge clk);
    pulse_req();
    wait_words(b + 21, "t3_wait_w20");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 1, "t3_wait_done");
    repeat (30) @(negedge clk);
    check("t3_total_words", 32'(q_words.size() - b), 32'd36);
    check("t3_done_count", 32'(n_done - d0), 32'd1);
    check("t3_bubble", 32'(q_cyc[b+18] - q_cyc[b+17]), 32'd2);
    bad = 0;
    for (int i = 0; i < 36; i++) if (q_words[b+i] !== 32'(i)) bad++;
    check("t3_seq", 32'(bad), 32'd0);
    check("t3_busy_idle", 32'(busy), 32'd0);

    // ---------------- Reset mid-pass ----------------
    b = q_words.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_words(b + 13, "t4_wait_w12");
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_rd_en", 32'(mem_rd_en), 32'd0);
    check("t4_async_addr",  32'(mem_addr),  32'd0);
    check("t4_async_wout",  weight_out,     32'd0);
    check("t4_async_valid", 32'(valid_weight_out), 32'd0);
    check("t4_async_busy",  32'(busy), 32'd0);
    check("t4_async_done",  32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_req();
    repeat (8) @(negedge clk);
    check("t4_quiet_words", 32'(q_words.size() - b), 32'd13);
    check("t4_quiet_rd_en", 32'(mem_rd_en), 32'd0);
    check("t4_quiet_busy",  32'(busy), 32'd0);

    // start and filter_req together in IDLE: the request must not release filter 1.
    b2 = q_words.size(); d0 = n_done;
    start = 1'b1; filter_req = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0; filter_req = 1'b0;
    wait_words(b2 + 18, "t4_wait_f0");
    check("t4_first_word", q_words[b2], 32'd0);
    check("t4_first_latency", 32'(q_cyc[b2] - c0), 32'd3);
    bad = 0;
    for (int i = 0; i < 18; i++) if (q_words[b2+i] !== 32'(i)) bad++;
    check("t4_seq_f0", 32'(bad), 32'd0);
    repeat (10) @(negedge clk);
    check("t4_no_f1_without_req", 32'(q_words.size() - b2), 32'd18);
    pulse_req();
    wait_done(d0 + 1, "t4_wait_done");
    check("t4_total_words", 32'(q_words.size() - b2), 32'd36);
    check("t4_last_word", q_words[b2+35], 32'd35);

    check("valid_outside_busy", 32'(n_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
